// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution and direction prediction.
// Op codes, 2-bit counter states and the sequential PC step.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQZ = 3'd1,
    BR_BNEZ = 3'd2,
    BR_BLTZ = 3'd3,
    BR_BGEZ = 3'd4,
    BR_JUMP = 3'd5
  } brOp_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int PC_INC = 2;

endpackage

// File: rtl/branch_bht.sv
// Table of 2-bit saturating direction counters.
// Combinational read for fetch, saturating update from MEM.
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output logic             rdTaken,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);

  logic [1:0] ctr [BHT_ENTRIES];
  logic [1:0] cur;

  assign rdTaken = ctr[rdIdx][1];
  assign cur     = ctr[wrIdx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr[i] <= CTR_WNT;
      end
    end else if (wrEn) begin
      if (wrTaken && cur != CTR_ST) begin
        ctr[wrIdx] <= cur + 2'd1;
      end else if (!wrTaken && cur != CTR_SNT) begin
        ctr[wrIdx] <= cur - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches into a MEM register, flags mispredicts,
// trains the direction table and keeps branch statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int BHT_ENTRIES = 16,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_rs,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic             stall,
  output logic             mem_valid,
  output logic             mem_taken,
  output logic             mem_mispredict,
  output logic [WIDTH-1:0] mem_redirect_pc,
  output logic [15:0]      br_count,
  output logic [15:0]      mispred_count
);

  logic             zf;
  logic             sf;
  logic             taken;
  logic             isBr;
  logic             capture;
  logic             retire;
  logic [WIDTH-1:0] seqPc;
  logic [IDX_W-1:0] memIdx;
  logic             memJump;
  logic             unusedIfPc;

  assign zf      = (ex_rs == '0);
  assign sf      = ex_rs[WIDTH-1];
  assign seqPc   = ex_pc + WIDTH'(PC_INC);
  assign capture = ex_valid & ~stall & ~mem_mispredict & isBr;
  assign retire  = mem_valid & ~stall;

  assign unusedIfPc = ^{if_pc[WIDTH-1:IDX_W+1], if_pc[0]};

  always_comb begin
    taken = 1'b0;
    isBr  = 1'b1;
    case (ex_op)
      BR_BEQZ: taken = zf;
      BR_BNEZ: taken = ~zf;
      BR_BLTZ: taken = sf;
      BR_BGEZ: taken = ~sf;
      BR_JUMP: taken = 1'b1;
      default: isBr  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid       <= 1'b0;
      mem_taken       <= 1'b0;
      mem_mispredict  <= 1'b0;
      mem_redirect_pc <= '0;
      memIdx          <= '0;
      memJump         <= 1'b0;
      br_count        <= '0;
      mispred_count   <= '0;
    end else if (!stall) begin
      mem_valid      <= capture;
      mem_mispredict <= capture & (taken ^ ex_pred_taken);
      if (capture) begin
        mem_taken       <= taken;
        mem_redirect_pc <= taken ? ex_target : seqPc;
        memIdx          <= ex_pc[IDX_W:1];
        memJump         <= (ex_op == BR_JUMP);
      end
      if (mem_valid && br_count != 16'hFFFF) begin
        br_count <= br_count + 16'd1;
      end
      if (mem_valid && mem_mispredict && mispred_count != 16'hFFFF) begin
        mispred_count <= mispred_count + 16'd1;
      end
    end
  end

  branch_bht #(
    .BHT_ENTRIES(BHT_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_bht (
    .clk    (clk),
    .rst    (rst),
    .rdIdx  (if_pc[IDX_W:1]),
    .rdTaken(if_pred_taken),
    .wrEn   (retire & ~memJump),
    .wrIdx  (memIdx),
    .wrTaken(mem_taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed
// expectations for resolution, squash, training, stall and reset.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] if_pc = '0;
  logic        if_pred_taken;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = '0;
  logic [15:0] ex_pc = '0;
  logic [15:0] ex_rs = '0;
  logic [15:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        stall = 1'b0;
  logic        mem_valid;
  logic        mem_taken;
  logic        mem_mispredict;
  logic [15:0] mem_redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .WIDTH      (16),
    .BHT_ENTRIES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_op          (ex_op),
    .ex_pc          (ex_pc),
    .ex_rs          (ex_rs),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .stall          (stall),
    .mem_valid      (mem_valid),
    .mem_taken      (mem_taken),
    .mem_mispredict (mem_mispredict),
    .mem_redirect_pc(mem_redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [2:0] op,
                    input logic [15:0] pc, input logic [15:0] rs,
                    input logic [15:0] tgt, input logic pr);
    ex_valid      = v;
    ex_op         = op;
    ex_pc         = pc;
    ex_rs         = rs;
    ex_target     = tgt;
    ex_pred_taken = pr;
  endtask

  task automatic pred(input string tag, input logic [15:0] pc,
                      input logic exp);
    if_pc = pc;
    #1;
    chk(tag, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mispred", {31'd0, mem_mispredict}, 32'd0);
    chk("rst_redirect", {16'd0, mem_redirect_pc}, 32'd0);
    chk("rst_brcnt", {16'd0, br_count}, 32'd0);
    chk("rst_mpcnt", {16'd0, mispred_count}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      pred($sformatf("rst_pred%0d", i), 16'(i * 2), 1'b0);
    end

    // BEQZ taken, predicted not-taken; next EX op is wrong-path
    ex(1, 3'd1, 16'h0010, 16'h0000, 16'h0040, 0);
    tick();
    chk("beqz_valid", {31'd0, mem_valid}, 32'd1);
    chk("beqz_taken", {31'd0, mem_taken}, 32'd1);
    chk("beqz_mp", {31'd0, mem_mispredict}, 32'd1);
    chk("beqz_redir", {16'd0, mem_redirect_pc}, 32'h40);
    ex(1, 3'd5, 16'h0020, 16'h0000, 16'h0300, 0);
    tick();
    chk("squash_valid", {31'd0, mem_valid}, 32'd0);
    chk("beqz_brcnt", {16'd0, br_count}, 32'd1);
    chk("beqz_mpcnt", {16'd0, mispred_count}, 32'd1);
    pred("beqz_train", 16'h0010, 1'b1);

    ex(1, 3'd3, 16'h0012, 16'h8000, 16'h0080, 1);
    tick();
    chk("bltz_taken", {31'd0, mem_taken}, 32'd1);
    chk("bltz_mp", {31'd0, mem_mispredict}, 32'd0);
    chk("bltz_redir", {16'd0, mem_redirect_pc}, 32'h80);
    ex(1, 3'd3, 16'h0012, 16'h0000, 16'h0080, 1);
    tick();
    chk("bltz0_taken", {31'd0, mem_taken}, 32'd0);
    chk("bltz0_mp", {31'd0, mem_mispredict}, 32'd1);
    chk("bltz0_redir", {16'd0, mem_redirect_pc}, 32'h14);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    ex(1, 3'd4, 16'h0014, 16'h0000, 16'h0060, 1);
    tick();
    chk("bgez0_taken", {31'd0, mem_taken}, 32'd1);
    chk("bgez0_mp", {31'd0, mem_mispredict}, 32'd0);
    chk("bgez0_redir", {16'd0, mem_redirect_pc}, 32'h60);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    chk("step3_brcnt", {16'd0, br_count}, 32'd4);
    chk("step3_mpcnt", {16'd0, mispred_count}, 32'd2);

    // Saturate entry 3, then walk it back down
    for (int i = 0; i < 5; i++) begin
      ex(1, 3'd2, 16'h0006, 16'h0001, 16'h0100, 1);
      tick();
    end
    ex(1, 3'd2, 16'h0006, 16'h0000, 16'h0100, 0);
    tick();
    tick();
    pred("sat_one_dec", 16'h0006, 1'b1);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    pred("sat_two_dec", 16'h0006, 1'b0);
    chk("sat_brcnt", {16'd0, br_count}, 32'd11);
    chk("sat_mpcnt", {16'd0, mispred_count}, 32'd2);

    // Stall holds the MEM register and counters
    ex(1, 3'd5, 16'h0020, 16'h0000, 16'h0200, 0);
    tick();
    chk("jmp_redir", {16'd0, mem_redirect_pc}, 32'h200);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, mem_valid}, 32'd1);
      chk("stall_mp", {31'd0, mem_mispredict}, 32'd1);
      chk("stall_redir", {16'd0, mem_redirect_pc}, 32'h200);
      chk("stall_brcnt", {16'd0, br_count}, 32'd11);
    end
    stall = 1'b0;
    tick();
    chk("unstall_brcnt", {16'd0, br_count}, 32'd12);
    chk("unstall_mpcnt", {16'd0, mispred_count}, 32'd3);
    chk("unstall_valid", {31'd0, mem_valid}, 32'd0);
    pred("jump_no_train", 16'h0020, 1'b0);

    // Not-taken at top of address space wraps to 0
    ex(1, 3'd1, 16'hFFFE, 16'h0005, 16'h0400, 0);
    tick();
    chk("wrap_taken", {31'd0, mem_taken}, 32'd0);
    chk("wrap_redir", {16'd0, mem_redirect_pc}, 32'h0);
    chk("wrap_mp", {31'd0, mem_mispredict}, 32'd0);

    // Reset with a resolution in flight
    ex(1, 3'd5, 16'h0000, 16'h0000, 16'h1234, 1);
    tick();
    chk("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst2_taken", {31'd0, mem_taken}, 32'd0);
    chk("rst2_redir", {16'd0, mem_redirect_pc}, 32'd0);
    chk("rst2_brcnt", {16'd0, br_count}, 32'd0);
    chk("rst2_mpcnt", {16'd0, mispred_count}, 32'd0);
    pred("rst2_pred8", 16'h0010, 1'b0);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    chk("rst2_discard", {31'd0, mem_valid}, 32'd0);
    chk("rst2_cnt_hold", {16'd0, br_count}, 32'd0);

    // Statistics saturate at all-ones
    force dut.br_count = 16'hFFFE;
    #1;
    release dut.br_count;
    for (int i = 0; i < 3; i++) begin
      ex(1, 3'd5, 16'h0030, 16'h0000, 16'h0500, 1);
      tick();
    end
    chk("satcnt_a", {16'd0, br_count}, 32'hFFFF);
    ex(0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    chk("satcnt_b", {16'd0, br_count}, 32'hFFFF);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and direction-prediction unit for the WISC pipeline, generalising the combinational branch-condition check. It evaluates the branch condition of the instruction in EX and registers the outcome into MEM. It detects mispredictions against the fetch-time prediction and produces the redirect PC. It also owns a PC-indexed table of 2-bit saturating counters, which fetch reads for predictions, plus saturating branch and mispredict statistics counters.

## Interface
Parameters:
- WIDTH, 16, datapath/PC width
- BHT_ENTRIES, 16, counter-table depth; power of two, ≥2
- IDX_W, $clog2(BHT_ENTRIES), derived; not overridden

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  WIDTH  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational prediction for if_pc
- ex_valid  in  1  EX holds a branch/jump op
- ex_op  in  3  branch op, encodings in branch_pkg
- ex_pc  in  WIDTH  PC of the EX instruction
- ex_rs  in  WIDTH  condition operand Rs
- ex_target  in  WIDTH  computed taken target
- ex_pred_taken  in  1  prediction carried from fetch
- stall  in  1  pipeline stall; freezes all state
- mem_valid  out  1  registered resolution valid
- mem_taken  out  1  resolved direction
- mem_mispredict  out  1  mem_taken != carried prediction
- mem_redirect_pc  out  WIDTH  correct next PC
- br_count  out  16  resolved branches, saturating
- mispred_count  out  16  mispredictions, saturating

## Operation
- Op codes: NONE=0, BEQZ=1, BNEZ=2, BLTZ=3, BGEZ=4, JUMP=5; codes 6–7 are treated as NONE.
- Flags come from ex_rs: ZF = (ex_rs == 0), SF = ex_rs[WIDTH-1].
- Taken conditions: BEQZ takes on ZF. BNEZ takes on ~ZF. BLTZ takes on SF. BGEZ takes on ~SF (zero counts as taken). JUMP is always taken. NONE is never taken.
- Capture: on a clock edge with ex_valid & ~stall & ~mem_mispredict and op ≠ NONE, the register loads:
  - mem_valid = 1
  - mem_taken = the resolved direction
  - mem_mispredict = taken ^ ex_pred_taken
  - mem_redirect_pc = taken ? ex_target : ex_pc + 2, modulo 2^WIDTH
- Otherwise, when ~stall, mem_valid and mem_mispredict load 0. The remaining output fields are don't-care while mem_valid = 0.
- Self-squash: while mem_mispredict = 1, the EX instruction is wrong-path and is never captured.
- Prediction table: BHT_ENTRIES 2-bit counters, indexed by pc[IDX_W:1] (halfword-aligned PC). if_pred_taken = counter[1].
- Table update happens at the edge where mem_valid & ~stall and the op was not JUMP:
  - taken → increment, saturating at 2'b11
  - not taken → decrement, saturating at 2'b00
  - The unit holds the MEM-stage index and op internally for this.
- Statistics:
  - br_count increments on every update edge with mem_valid & ~stall, JUMP included.
  - mispred_count increments on the same edge when mem_mispredict is also 1.
  - Both saturate at 16'hFFFF.

## Timing
- Resolution latency is one cycle from the EX capture edge; mem_* is valid for exactly one cycle unless stall holds it.
- Stall = 1 holds every register, the table and the counters; the mem_* outputs stay at their current values.
- if_pred_taken is combinational from the table. A same-cycle update to the indexed entry is not bypassed: fetch sees the old value.
- Reset (rst = 1 at an edge) takes priority over stall and capture. It sets:
  - mem_valid, mem_taken, mem_mispredict = 0
  - mem_redirect_pc = 0
  - br_count, mispred_count = 0
  - every table entry = 2'b01 (weakly not-taken)
  - any branch in flight when reset arrives is discarded
- ex_pc + 2 at the top of the address space wraps to 0.

## Structure
- branch_pkg holds:
  - op encodings (BR_NONE … BR_JUMP)
  - counter constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - the PC increment constant PC_INC=2
- One sub-module, branch_bht, is natural. It owns the counter array, the combinational read port and the saturating-update write port. Parameters: BHT_ENTRIES, IDX_W.
- Condition evaluation, the MEM register and the statistics counters live in the top level.

## Test plan
- Reset, then read all 16 table entries → if_pred_taken = 0 everywhere; br_count = 0.
- BEQZ, ex_rs=0, ex_pc=16'h0010, ex_target=16'h0040, pred=0 → next cycle: mem_taken=1, mem_mispredict=1, redirect=16'h0040. The following EX op is squashed (mem_valid=0 the cycle after). Entry 8 becomes 2'b10, so if_pc=16'h0010 predicts taken.
- BLTZ, ex_rs=16'h8000, pred=1 → mem_mispredict=0. Same op with ex_rs=16'h0000, pred=1 → mispredict, redirect = ex_pc + 2. BGEZ with ex_rs=0 → taken.
- Five taken BNEZ at one PC → counter saturates at 2'b11. Two not-taken → 2'b01; predict not-taken.
- stall=1 for 3 cycles with mem_valid=1 → mem_* outputs, table and counters are unchanged; exactly one count once stall drops.
- Force br_count to 16'hFFFE, resolve 3 branches → 16'hFFFF. Assert rst mid-stream with mem_valid=1 → all outputs 0 next cycle.
